uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver, counterpart of the UART transmitter: 8N1-style frames, LSB first.
//   Synchronises the rx pin, validates the start bit and samples each bit at mid-period.
//   Checks the stop bit and presents each word on a valid/ready stream with a single holding register.
//   Flags framing errors and overruns. Sits between the board rx pin and the host-side stream logic.
// PARAMETERS
//   NUMBER_OF_BITS  8  data bits per frame (>=1)
//   BAUD_DIVIDER    4  clocks per bit (>=2); must match the transmitter's divider
// PORTS
//   clock          in   1               single clock; all logic on posedge
//   reset          in   1               asynchronous, active-high
//   rx             in   1               serial line, idle high, asynchronous to clock
//   data_valid     out  1               holding register full
//   data_ready     in   1               consumer accepts when data_valid && data_ready
//   data_bits      out  NUMBER_OF_BITS  received word, bit 0 = first data bit on the line
//   framing_error  out  1               1-clock pulse: stop bit sampled 0
//   overrun        out  1               1-clock pulse: good frame dropped, holding register full
// BEHAVIOUR
//   Reset (async assert, sync-released use): state=IDLE, sync FFs=1, data_valid=0, data_bits=0,
//     framing_error=0, overrun=0, counters=0. Reset mid-frame abandons the frame silently.
//   Synchroniser: 2 FFs, reset to 1. rx_s = second FF output. All decisions use rx_s only.
//   Constants: HALF = BAUD_DIVIDER/2 - 1. Rate counter width $clog2(BAUD_DIVIDER), bit index $clog2(NUMBER_OF_BITS+1).
//   States:
//     IDLE      rx_s==0 at edge T0 -> START, rate_counter<=HALF.
//     START     counter!=0: decrement. counter==0 (edge T0+HALF+1): sample rx_s.
//               0 -> DATA, idx<=0, counter<=BAUD_DIVIDER-1. 1 -> IDLE (glitch rejected, no flag).
//     DATA      every BAUD_DIVIDER clocks sample rx_s into shift reg (shift right, MSB in).
//               After NUMBER_OF_BITS samples -> STOP, counter reloaded.
//     STOP      sample at T0+HALF+1+(NUMBER_OF_BITS+1)*BAUD_DIVIDER.
//               1 -> deliver word, IDLE. 0 -> framing_error pulse, word discarded, BREAK.
//     BREAK     wait for rx_s==1, then IDLE (a held-low line gives exactly one framing_error).
//   Return to IDLE at the mid-stop-bit sample. The next start edge is accepted immediately,
//     so back-to-back frames are received with zero idle bits.
//   Delivery (cycle after the stop sample, i.e. edge T0+HALF+2+(NUMBER_OF_BITS+1)*BAUD_DIVIDER):
//     data_valid==0                    -> data_bits<=word, data_valid<=1.
//     data_valid && data_ready         -> same cycle: data_bits<=new word, data_valid stays 1, no overrun.
//     data_valid && !data_ready        -> new word dropped, old word held unchanged, overrun pulse.
//   Handshake: data_bits stable while data_valid && !data_ready. data_valid falls the edge after a
//     transfer unless a word is delivered in that same cycle. No combinational path from data_ready.
//   Outputs are registered. framing_error and overrun are never asserted in the same cycle.
// STRUCTURE
//   uart_pkg: typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,STOP,BREAK}.
//     Shared with uart_tx: default NUMBER_OF_BITS/BAUD_DIVIDER localparams.
//   Sub-module sync_2ff (parameter RESET_VALUE=1'b1, async reset) for the rx synchroniser.
//   The rest is one always_ff FSM plus the output holding register.
// TESTING (BAUD_DIVIDER=4, NUMBER_OF_BITS=8, loopback from uart_tx and direct pin drive)
//   Single frame 0xA5, data_ready=1 -> data_bits=0xA5, one-cycle valid; start edge to valid = 39+2 clocks.
//   Back-to-back 0x00,0xFF,0x55 from uart_tx -> 3 words in order, no framing_error/overrun.
//   Two frames, data_ready=0 -> first word 0x3C held; overrun pulse at the second stop; 0x3C read afterwards.
//   Low glitch of 1 clock on idle line -> returns to IDLE, no data_valid, no flags.
//   Frame 0x81 with stop bit 0, then line low 40 clocks -> one framing_error, no data_valid;
//     after line high, next frame 0x12 received correctly.
//   Assert reset in the middle of DATA -> all outputs 0 immediately; the following clean frame 0x7E is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  localparam int DEFAULT_NUMBER_OF_BITS = 8;
  localparam int DEFAULT_BAUD_DIVIDER   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of LSB-first frames, stop-bit check, and a single-word
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
  parameter int BAUD_DIVIDER   = DEFAULT_BAUD_DIVIDER
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [NUMBER_OF_BITS-1:0] data_bits,
  output logic                      framing_error,
  output logic                      overrun,
  output uart_rx_state_t            state_dbg
);

  // Stream handshake: a word transfers on any clock edge where data_valid && data_ready;
  // data_bits holds steady while data_valid && !data_ready, and data_ready only feeds flops.

  localparam int CW = $clog2(BAUD_DIVIDER);
  localparam int IW = $clog2(NUMBER_OF_BITS + 1);
  localparam logic [CW-1:0] HALF     = CW'(BAUD_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] RELOAD   = CW'(BAUD_DIVIDER - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t            state_q,         state_d;
  logic [CW-1:0]             rate_cnt_q,      rate_cnt_d;
  logic [IW-1:0]             bit_idx_q,       bit_idx_d;
  logic [NUMBER_OF_BITS-1:0] shift_q,         shift_d;
  logic                      deliver_q,       deliver_d;
  logic                      data_valid_q,    data_valid_d;
  logic [NUMBER_OF_BITS-1:0] data_bits_q,     data_bits_d;
  logic                      framing_error_q, framing_error_d;
  logic                      overrun_q,       overrun_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rate_cnt_q      <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      deliver_q       <= 1'b0;
      data_valid_q    <= 1'b0;
      data_bits_q     <= '0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rate_cnt_q      <= rate_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      deliver_q       <= deliver_d;
      data_valid_q    <= data_valid_d;
      data_bits_q     <= data_bits_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rate_cnt_d      = rate_cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    deliver_d       = 1'b0;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;
    data_valid_d    = data_valid_q;
    data_bits_d     = data_bits_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          rate_cnt_d = HALF;
        end
      end
      START: begin
        if (rate_cnt_q != '0) begin
          rate_cnt_d = rate_cnt_q - CW'(1);
        end else if (!rx_s) begin
          state_d    = DATA;
          bit_idx_d  = '0;
          rate_cnt_d = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rate_cnt_q != '0) begin
          rate_cnt_d = rate_cnt_q - CW'(1);
        end else begin
          shift_d                     = shift_q >> 1;
          shift_d[NUMBER_OF_BITS-1]   = rx_s;
          bit_idx_d                   = bit_idx_q + IW'(1);
          rate_cnt_d                  = RELOAD;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (rate_cnt_q != '0) begin
          rate_cnt_d = rate_cnt_q - CW'(1);
        end else if (rx_s) begin
          // Back to IDLE at mid-stop so a start bit right after the stop bit is caught.
          deliver_d = 1'b1;
          state_d   = IDLE;
        end else begin
          framing_error_d = 1'b1;
          state_d         = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // shift_q is untouched outside DATA, so it still holds the word on the delivery cycle.
    if (deliver_q) begin
      if (!data_valid_q || data_ready) begin
        data_bits_d  = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_valid    = data_valid_q;
  assign data_bits     = data_bits_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized pin-level stimulus for uart_rx, checked against a word-level reference.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int NB  = 8;
  localparam int BD  = 4;
  // Clock edges from the drive of the start bit to data_valid visible: 1 + (39 + 2).
  localparam int LAT = 42;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          data_ready = 1'b1;
  logic          data_valid;
  logic [NB-1:0] data_bits;
  logic          framing_error;
  logic          overrun;
  uart_rx_state_t state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_start_cyc = 0;

  // monitor-owned observations
  logic [NB-1:0] got_q[$];
  int   valid_rises = 0;
  int   valid_high = 0;
  int   rise_cyc = 0;
  int   fe_count = 0;
  int   ov_count = 0;
  int   ov_cyc = 0;
  int   both_count = 0;
  logic valid_prev = 1'b0;

  // reference model state
  logic [NB-1:0] exp_q[$];
  int   rd_idx = 0;

  uart_rx #(.NUMBER_OF_BITS(NB), .BAUD_DIVIDER(BD)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data_bits     (data_bits),
    .framing_error (framing_error),
    .overrun       (overrun),
    .state_dbg     (state_dbg)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, observed cyc=%0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // scoreboard-side monitor: samples mid-low-phase, after the bench drives its inputs
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (data_valid && data_ready) got_q.push_back(data_bits);
      if (data_valid) valid_high++;
      if (data_valid && !valid_prev) begin
        valid_rises++;
        rise_cyc = cyc;
      end
      if (framing_error) fe_count++;
      if (overrun) begin
        ov_count++;
        ov_cyc = cyc;
      end
      if (framing_error && overrun) both_count++;
    end
    valid_prev = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: every call starts and ends on a falling clock edge
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BD) @(negedge clock);
  endtask

  task automatic send_frame(input logic [NB-1:0] w, input logic stop_bit);
    last_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < NB; i++) drive_bit(w[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic compare_words(input string tag);
    int n;
    n = got_q.size() - rd_idx;
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (rd_idx < got_q.size()) check(tag, 32'(got_q[rd_idx]), 32'(exp_q[0]));
      rd_idx++;
      void'(exp_q.pop_front());
    end
    rd_idx = got_q.size();
  endtask

  initial begin
    int fe0, ov0, vr0, vh0;
    logic [NB-1:0] w;
    int gap;

    // reset
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_bits", 32'(data_bits), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_ov", 32'(overrun), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    idle(4);

    // single frame 0xA5, consumer always ready
    vh0 = valid_high;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    idle(4);
    check("a5_latency", 32'(rise_cyc - last_start_cyc), 32'(LAT));
    check("a5_valid_cycles", 32'(valid_high - vh0), 32'd1);
    compare_words("a5_word");

    // back-to-back frames with zero idle bits
    fe0 = fe_count; ov0 = ov_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    idle(4);
    compare_words("b2b_word");
    check("b2b_fe", 32'(fe_count - fe0), 32'd0);
    check("b2b_ov", 32'(ov_count - ov0), 32'd0);

    // overrun: consumer stalled across two frames
    data_ready = 1'b0;
    w = 8'($urandom_range(0, 255));
    ov0 = ov_count;
    send_frame(8'h3C, 1'b1);
    send_frame(w, 1'b1);
    idle(4);
    check("ovr_count", 32'(ov_count - ov0), 32'd1);
    check("ovr_timing", 32'(ov_cyc - last_start_cyc), 32'(LAT));
    check("ovr_hold_valid", 32'(data_valid), 32'd1);
    check("ovr_hold_bits", 32'(data_bits), 32'h3C);
    data_ready = 1'b1;
    exp_q.push_back(8'h3C);
    idle(3);
    check("ovr_drained_valid", 32'(data_valid), 32'd0);
    compare_words("ovr_word");

    // single-clock low glitch on an idle line
    vr0 = valid_rises; fe0 = fe_count; ov0 = ov_count;
    rx = 1'b0;
    @(negedge clock);
    idle(20);
    check("glitch_valid", 32'(valid_rises - vr0), 32'd0);
    check("glitch_flags", 32'((fe_count - fe0) + (ov_count - ov0)), 32'd0);
    check("glitch_state", 32'(state_dbg), 32'(IDLE));

    // bad stop bit followed by a held-low line, then a clean frame
    vr0 = valid_rises; fe0 = fe_count;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    idle(2 * BD);
    check("frame_err_count", 32'(fe_count - fe0), 32'd1);
    check("frame_err_novalid", 32'(valid_rises - vr0), 32'd0);
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    idle(4);
    compare_words("after_break_word");

    // reset in the middle of DATA with a word still held
    data_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    idle(4);
    check("pre_reset_bits", 32'(data_bits), 32'h99);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("mid_data_state", 32'(state_dbg), 32'(DATA));
    reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(data_valid), 32'd0);
    check("async_reset_bits", 32'(data_bits), 32'd0);
    check("async_reset_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    data_ready = 1'b1;
    idle(8);
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    idle(4);
    compare_words("post_reset_word");

    // randomized words and inter-frame gaps
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      send_frame(w, 1'b1);
      exp_q.push_back(w);
      if (gap > 0) idle(gap * BD);
    end
    idle(6);
    compare_words("rand_word");

    check("fe_ov_exclusive", 32'(both_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
